// File: rtl/acc_requant_pkg.sv
// Shared definitions for the accumulator requantiser.
// Contents: per-beat mode encoding and helpers giving the signed output range.
package acc_requant_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC    = 2'd0,
        MODE_SAT      = 2'd1,
        MODE_RND_SAT  = 2'd2,
        MODE_RELU_SAT = 2'd3
    } mode_e;

    // Largest value representable in a w-bit two's complement result.
    function automatic int out_max(input int unsigned w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    // Smallest value representable in a w-bit two's complement result.
    function automatic int out_min(input int unsigned w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/requant_lane.sv
// Combinational per-lane requantisation, split into the two pipeline halves.
// Ports:
//   x, mode_s1        : raw accumulator lane and its mode (stage 1 inputs)
//   t_c               : shifted / rounded value, IN_W+1 bits signed
//   t, mode_s2        : registered stage-1 value and mode (stage 2 inputs)
//   y_c, ovf_c        : narrowed OUT_W-bit result and its overflow flag
module requant_lane
    import acc_requant_pkg::*;
#(
    parameter int unsigned IN_W       = 22,
    parameter int unsigned OUT_W      = 9,
    parameter int unsigned FRAC_SHIFT = 5
) (
    input  logic        [IN_W-1:0]  x,
    input  mode_e                   mode_s1,
    output logic signed [IN_W:0]    t_c,
    input  logic signed [IN_W:0]    t,
    input  mode_e                   mode_s2,
    output logic        [OUT_W-1:0] y_c,
    output logic                    ovf_c
);

    localparam int unsigned TW = IN_W + 1;
    localparam logic signed [TW-1:0] MAX_T = TW'(out_max(OUT_W));
    localparam logic signed [TW-1:0] MIN_T = TW'(out_min(OUT_W));
    localparam logic signed [TW-1:0] HALF  = TW'(2 ** (FRAC_SHIFT - 1));

    logic signed [TW-1:0] xe;
    logic signed [TW-1:0] rnd;
    logic                 over;
    logic                 under;

    // Stage 1: sign-extend one bit so rounding at the top of range cannot wrap.
    always_comb begin
        xe  = {x[IN_W-1], x};
        rnd = '0;
        if (mode_s1 == MODE_RND_SAT) begin
            rnd = HALF;
        end
        t_c = (xe + rnd) >>> FRAC_SHIFT;
    end

    // Stage 2: narrow with wrap, clamp or ReLU clamp.
    always_comb begin
        over  = (t > MAX_T);
        under = (t < MIN_T);
        y_c   = t[OUT_W-1:0];
        ovf_c = over | under;
        case (mode_s2)
            MODE_TRUNC: begin
            end
            MODE_SAT, MODE_RND_SAT: begin
                if (over) begin
                    y_c = MAX_T[OUT_W-1:0];
                end else if (under) begin
                    y_c = MIN_T[OUT_W-1:0];
                end
            end
            MODE_RELU_SAT: begin
                ovf_c = over;
                if (t[TW-1]) begin
                    y_c = '0;
                end else if (over) begin
                    y_c = MAX_T[OUT_W-1:0];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/acc_requant_pipe.sv
// Two-stage stall-all requantiser between the accumulator bank and the
// activation buffer, with per-lane overflow, sticky flags and event counter.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_data packs N_CH IN_W lanes
//   in_mode              : per-beat mode, captured on acceptance
//   out_valid/out_ready  : output handshake; out_data packs N_CH OUT_W lanes
//   out_ovf              : per-lane overflow of the presented beat
//   sticky_ovf, ovf_cnt  : accumulated overflow status; clear zeroes both
module acc_requant_pipe
    import acc_requant_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned IN_W       = 22,
    parameter int unsigned OUT_W      = 9,
    parameter int unsigned FRAC_SHIFT = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*IN_W-1:0]    in_data,
    input  logic [1:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_CH*OUT_W-1:0]   out_data,
    output logic [N_CH-1:0]         out_ovf,
    output logic [N_CH-1:0]         sticky_ovf,
    output logic [CNT_W-1:0]        ovf_cnt,
    input  logic                    clear
);

    localparam int unsigned TW = IN_W + 1;

    logic                    en;
    logic                    xfer;
    mode_e                   in_mode_e;
    logic                    s1_valid;
    mode_e                   s1_mode;
    logic signed [TW-1:0]    s1_t [N_CH];
    logic signed [TW-1:0]    t_c  [N_CH];
    logic [OUT_W-1:0]        y_c  [N_CH];
    logic [N_CH-1:0]         ovf_c;
    logic [N_CH*OUT_W-1:0]   out_data_c;
    logic [N_CH-1:0]         sticky_c;
    logic [CNT_W-1:0]        cnt_c;

    // Whole pipeline advances only when the output register is free or drained.
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign xfer      = out_valid && out_ready;
    assign in_mode_e = mode_e'(in_mode);

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        requant_lane #(
            .IN_W       (IN_W),
            .OUT_W      (OUT_W),
            .FRAC_SHIFT (FRAC_SHIFT)
        ) u_lane (
            .x       (in_data[i*IN_W +: IN_W]),
            .mode_s1 (in_mode_e),
            .t_c     (t_c[i]),
            .t       (s1_t[i]),
            .mode_s2 (s1_mode),
            .y_c     (y_c[i]),
            .ovf_c   (ovf_c[i])
        );
    end

    // Pack lane results for the output register.
    always_comb begin
        out_data_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            out_data_c[i*OUT_W +: OUT_W] = y_c[i];
        end
    end

    // Stage 1 register: shifted lanes plus the mode they were accepted with.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_TRUNC;
            for (int i = 0; i < N_CH; i++) begin
                s1_t[i] <= '0;
            end
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode_e;
                for (int i = 0; i < N_CH; i++) begin
                    s1_t[i] <= t_c[i];
                end
            end
        end
    end

    // Stage 2 register: presented output beat, held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= out_data_c;
                out_ovf  <= ovf_c;
            end
        end
    end

    // Clear takes effect first, then the same-cycle transfer's event applies.
    always_comb begin
        sticky_c = clear ? '0 : sticky_ovf;
        cnt_c    = clear ? '0 : ovf_cnt;
        if (xfer) begin
            sticky_c = sticky_c | out_ovf;
            if ((|out_ovf) && (cnt_c != {CNT_W{1'b1}})) begin
                cnt_c = cnt_c + CNT_W'(1);
            end
        end
    end

    // Overflow status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf <= '0;
            ovf_cnt    <= '0;
        end else begin
            sticky_ovf <= sticky_c;
            ovf_cnt    <= cnt_c;
        end
    end

endmodule

// File: tb/tb_acc_requant_pipe.sv
// Scoreboard bench for acc_requant_pipe: expected beats are queued at input
// acceptance from an arithmetic reference model and popped on each transfer.
module tb_acc_requant_pipe;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned IN_W  = 22;
    localparam int unsigned OUT_W = 9;
    localparam int unsigned FS    = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DW    = N_CH * IN_W;
    localparam int unsigned OW    = N_CH * OUT_W;
    localparam longint      CMAX  = 65535;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic [N_CH-1:0]   out_ovf;
    logic [N_CH-1:0]   sticky_ovf;
    logic [CNT_W-1:0]  ovf_cnt;
    logic              clear;

    acc_requant_pipe #(
        .N_CH (N_CH), .IN_W (IN_W), .OUT_W (OUT_W), .FRAC_SHIFT (FS), .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .sticky_ovf (sticky_ovf),
        .ovf_cnt    (ovf_cnt),
        .clear      (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [OW-1:0]   exp_d [$];
    logic [N_CH-1:0] exp_o [$];
    logic [N_CH-1:0] m_sticky = '0;
    longint          m_cnt    = 0;

    int unsigned ordy_pct   = 100;
    int          stall_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on each lane.
    function automatic void ref_beat(input logic [DW-1:0] d, input logic [1:0] m,
                                     output logic [OW-1:0] yd, output logic [N_CH-1:0] ov);
        longint x, t, y, maxv, minv;
        maxv = (64'sd1 <<< (OUT_W - 1)) - 1;
        minv = -(64'sd1 <<< (OUT_W - 1));
        yd = '0;
        ov = '0;
        for (int i = 0; i < N_CH; i++) begin
            x = longint'($signed(d[i*IN_W +: IN_W]));
            if (m == 2'd2) t = (x + (64'sd1 <<< (FS - 1))) >>> FS;
            else           t = x >>> FS;
            case (m)
                2'd0: begin
                    y = t;
                    ov[i] = (t > maxv) || (t < minv);
                end
                2'd1, 2'd2: begin
                    y = (t > maxv) ? maxv : ((t < minv) ? minv : t);
                    ov[i] = (t > maxv) || (t < minv);
                end
                default: begin
                    y = (t < 0) ? 0 : ((t > maxv) ? maxv : t);
                    ov[i] = (t > maxv);
                end
            endcase
            yd[i*OUT_W +: OUT_W] = OUT_W'(y);
        end
    endfunction

    function automatic logic [DW-1:0] pack(input int a, input int b, input int c, input int e);
        logic [DW-1:0] r;
        r = '0;
        r[0*IN_W +: IN_W] = IN_W'(a);
        r[1*IN_W +: IN_W] = IN_W'(b);
        r[2*IN_W +: IN_W] = IN_W'(c);
        r[3*IN_W +: IN_W] = IN_W'(e);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom);
                1:       v = 8192 + int'($urandom_range(0, 128)) - 64;
                2:       v = -8192 + int'($urandom_range(0, 128)) - 64;
                default: v = int'($urandom_range(0, 16000)) - 8000;
            endcase
            r[i*IN_W +: IN_W] = IN_W'(v);
        end
        return r;
    endfunction

    task automatic set_ordy();
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = ($urandom_range(0, 99) < ordy_pct);
        end
    endtask

    // Present a beat and hold it until accepted.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] m);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            rst      = 1'b0;
            clear    = 1'b0;
            in_valid = 1'b1;
            in_data  = d;
            in_mode  = m;
            set_ordy();
            #1;
            guard++;
        end while (!in_ready && guard < 200);
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
    endtask

    task automatic idle(input logic clr);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = rand_beat();
        in_mode  = 2'($urandom);
        clear    = clr;
        set_ordy();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        ordy_pct = 100;
        for (int g = 0; g < 100 && !done; g++) begin
            idle(1'b0);
            #3;
            if (exp_d.size() == 0) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_d.size());
        end
        idle(1'b0);
        #3;
    endtask

    // Monitor: compares outputs and status against the scoreboard each cycle.
    initial begin : monitor
        logic            prev_stall;
        logic            after_rst;
        logic [OW-1:0]   prev_d, ed;
        logic [N_CH-1:0] prev_o, eo;
        prev_stall = 1'b0;
        after_rst  = 1'b0;
        prev_d     = '0;
        prev_o     = '0;
        forever begin
            @(negedge clk);
            #2;
            if (after_rst) begin
                chk("rst_out_valid", 64'(out_valid), 64'(0));
                chk("rst_out_data", 64'(out_data), 64'(0));
                chk("rst_out_ovf", 64'(out_ovf), 64'(0));
                after_rst = 1'b0;
            end
            if (rst) begin
                exp_d.delete();
                exp_o.delete();
                m_sticky   = '0;
                m_cnt      = 0;
                prev_stall = 1'b0;
                after_rst  = 1'b1;
            end else begin
                chk("sticky_ovf", 64'(sticky_ovf), 64'(m_sticky));
                chk("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
                if (prev_stall) begin
                    chk("hold_valid", 64'(out_valid), 64'(1));
                    chk("hold_data", 64'(out_data), 64'(prev_d));
                    chk("hold_ovf", 64'(out_ovf), 64'(prev_o));
                end
                if (out_valid && !out_ready) chk("in_ready_stall", 64'(in_ready), 64'(0));
                if (clear) begin
                    m_sticky = '0;
                    m_cnt    = 0;
                end
                if (out_valid && out_ready) begin
                    if (exp_d.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output actual=0x%0h required=none", out_data);
                    end else begin
                        ed = exp_d.pop_front();
                        eo = exp_o.pop_front();
                        chk("out_data", 64'(out_data), 64'(ed));
                        chk("out_ovf", 64'(out_ovf), 64'(eo));
                        m_sticky = m_sticky | eo;
                        if ((|eo) && m_cnt < CMAX) m_cnt++;
                    end
                end
                if (in_valid && in_ready) begin
                    ref_beat(in_data, in_mode, ed, eo);
                    exp_d.push_back(ed);
                    exp_o.push_back(eo);
                end
                prev_stall = out_valid && !out_ready;
                prev_d     = out_data;
                prev_o     = out_ovf;
            end
        end
    end

    initial begin : stim
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'd0;
        out_ready = 1'b1;
        clear     = 1'b0;
        repeat (3) @(negedge clk);

        // SAT boundary around +255
        send(pack(8160, 8192, 0, 0), 2'd1);
        drain();
        chk("sat_first_cnt", 64'(ovf_cnt), 64'(1));
        chk("sat_first_sticky", 64'(sticky_ovf), 64'(4'b0010));

        // TRUNC wrap and SAT low boundary
        send(pack(8192, 100, -32, 0), 2'd0);
        send(pack(-8224, -8192, 0, 0), 2'd1);
        // Rounding, including the top of the input range
        send(pack(8175, 8176, 2097151, -2097152), 2'd2);
        send(pack(8176, -17, 15, 16), 2'd0);
        send(pack(-16, -17, 15, 16), 2'd2);
        // ReLU clamp
        send(pack(-100, 9000, 3200, 8191), 2'd3);
        drain();

        // Backpressure mid-stream
        ordy_pct = 100;
        for (int b = 0; b < 6; b++) begin
            send(rand_beat(), 2'($urandom));
            if (b == 2) stall_left = 3;
        end
        drain();

        // Random traffic with random stalls, idles and clears
        ordy_pct = 70;
        for (int b = 0; b < 400; b++) begin
            send(rand_beat(), 2'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 15) == 0);
        end
        drain();

        // Counter saturation
        ordy_pct = 100;
        for (int b = 0; b < 65539; b++) send(pack(8192, 0, 0, 0), 2'd1);
        drain();
        chk("cnt_saturated", 64'(ovf_cnt), 64'(65535));

        // Clear coinciding with an overflowing transfer
        send(pack(8192, 0, 0, 0), 2'd1);
        idle(1'b0);
        idle(1'b1);
        #3;
        chk("clear_xfer_aligned", 64'(out_valid && out_ready), 64'(1));
        idle(1'b0);
        #3;
        chk("clear_plus_event_cnt", 64'(ovf_cnt), 64'(1));
        chk("clear_plus_event_sticky", 64'(sticky_ovf), 64'(4'b0001));
        drain();

        // Reset in the middle of a stream
        send(pack(8192, 8192, 0, 0), 2'd1);
        send(pack(0, 0, 8192, 0), 2'd1);
        send(pack(0, 0, 0, 8192), 2'd1);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = pack(8192, 8192, 8192, 8192);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #3;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_cnt", 64'(ovf_cnt), 64'(0));
        chk("midrst_sticky", 64'(sticky_ovf), 64'(0));
        drain();
        send(pack(-9000, 500, 0, 8192), 2'd3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
